// File: rtl/led_event_monitor_if.sv
// Bundle of the event/mode/clear inputs and LED/seen outputs of led_event_monitor.
// The master side drives triggers and configuration; the slave side is the monitor.
interface led_event_monitor_if #(
  parameter int NUM_CH = 4
);
  logic [NUM_CH-1:0]   event_in;
  logic [2*NUM_CH-1:0] mode;
  logic                clear;
  logic [NUM_CH-1:0]   led;
  logic [NUM_CH-1:0]   seen;

  modport master (output event_in, mode, clear, input led, seen);
  modport slave  (input event_in, mode, clear, output led, seen);
endinterface

// File: rtl/led_event_monitor.sv
// Per-channel LED driver: OFF / STICKY / BLINK / STRETCH on event triggers,
// plus a sticky "seen" flag per channel.
//
// state  | meaning
// IDLE   | no LED activity pending for the channel
// ACTIVE | sticky latched, blinking, or stretch window running
module led_event_monitor #(
  parameter int NUM_CH      = 4,
  parameter int HALF_PERIOD = 100_000_000,
  parameter int STRETCH     = 10_000_000
) (
  input logic              clk,
  input logic              rst,
  led_event_monitor_if.slave bus
);
  localparam int CNT_MAX = (HALF_PERIOD > STRETCH) ? HALF_PERIOD : STRETCH;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] BLINK_LAST   = CNT_W'(HALF_PERIOD - 1);
  localparam logic [CNT_W-1:0] STRETCH_LOAD = CNT_W'(STRETCH - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;
  typedef enum logic [1:0] {MODE_OFF, MODE_STICKY, MODE_BLINK, MODE_STRETCH} mode_t;

  state_t           state_q [NUM_CH];
  state_t           state_d [NUM_CH];
  logic [CNT_W-1:0] cnt_q   [NUM_CH];
  logic [CNT_W-1:0] cnt_d   [NUM_CH];
  mode_t            mode_q  [NUM_CH];
  mode_t            mode_d  [NUM_CH];
  mode_t            mode_in [NUM_CH];
  logic [NUM_CH-1:0] led_q, led_d;
  logic [NUM_CH-1:0] seen_q, seen_d;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      mode_in[i] = mode_t'(bus.mode[2*i +: 2]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
        mode_q[i]  <= MODE_OFF;
      end
      led_q  <= '0;
      seen_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        mode_q[i]  <= mode_d[i];
      end
      led_q  <= led_d;
      seen_q <= seen_d;
    end
  end

  always_comb begin
    led_d  = led_q;
    seen_d = seen_q;
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      mode_d[i]  = mode_q[i];
      if (bus.clear) begin
        // clear beats a coincident trigger; the mode copy still tracks the input
        state_d[i] = IDLE;
        cnt_d[i]   = '0;
        led_d[i]   = 1'b0;
        seen_d[i]  = 1'b0;
        mode_d[i]  = mode_in[i];
      end else begin
        if (bus.event_in[i]) seen_d[i] = 1'b1;
        if (mode_in[i] != mode_q[i]) begin
          mode_d[i]  = mode_in[i];
          state_d[i] = IDLE;
          cnt_d[i]   = '0;
          led_d[i]   = 1'b0;
        end else begin
          case (mode_q[i])
            MODE_OFF: begin
              state_d[i] = IDLE;
              cnt_d[i]   = '0;
              led_d[i]   = 1'b0;
            end
            MODE_STICKY: begin
              if (bus.event_in[i]) begin
                state_d[i] = ACTIVE;
                led_d[i]   = 1'b1;
              end
            end
            MODE_BLINK: begin
              if (state_q[i] == IDLE) begin
                if (bus.event_in[i]) begin
                  state_d[i] = ACTIVE;
                  cnt_d[i]   = '0;
                end
              end else if (cnt_q[i] == BLINK_LAST) begin
                cnt_d[i] = '0;
                led_d[i] = ~led_q[i];
              end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
              end
            end
            MODE_STRETCH: begin
              if (bus.event_in[i]) begin
                state_d[i] = ACTIVE;
                cnt_d[i]   = STRETCH_LOAD;
                led_d[i]   = 1'b1;
              end else if (state_q[i] == ACTIVE) begin
                if (cnt_q[i] != '0) begin
                  cnt_d[i] = cnt_q[i] - 1'b1;
                end else begin
                  state_d[i] = IDLE;
                  led_d[i]   = 1'b0;
                end
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign bus.led  = led_q;
  assign bus.seen = seen_q;
endmodule
